bcd_7seg: RTL and testbench

- Registered 4-bit-to-7-segment decoder driving one digit of the board's seven-segment display.
- Two instances, one per nibble, sit under the shifter/LFSR demo. They drive hex0 from the low nibble and hex1 from the high nibble of an 8-bit register.
- Decodes 0–F in hex mode, or 0–9 with blanking above 9 in BCD mode.
- Output polarity is selectable.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_lut.sv | 25 ++
 rtl/bcd_7seg.sv | 51 +++++
 tb/tb_bcd_7seg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment digit drivers.
// Patterns are stored active-low; bit 0 is segment a, bit 6 is segment g.
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_BLANK_AL = 7'h7F;

   // Entry 15 first, entry 0 last.
   localparam logic [15:0][6:0] SEG_TABLE_AL = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg7_lut.sv
// Combinational nibble to active-low segment pattern lookup.
// Codes above 9 blank the digit unless HEX_MODE is set.
module seg7_lut
   import seg7_pkg::*;
#(
   parameter bit HEX_MODE = 1'b1
) (
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK_AL;
      case (nib_i) inside
         [4'h0:4'h9]: seg_o = SEG_TABLE_AL[nib_i];
         [4'hA:4'hF]: begin
            if (HEX_MODE) begin
               seg_o = SEG_TABLE_AL[nib_i];
            end
         end
         default: seg_o = SEG_BLANK_AL;
      endcase
   end

endmodule

// File: rtl/bcd_7seg.sv
// Registered single-digit seven-segment driver with enable
// and selectable output polarity.
module bcd_7seg
   import seg7_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1,
   parameter bit HEX_MODE   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] b,
   output logic [6:0] h
);

   localparam logic [6:0] BLANK_OUT =
      ACTIVE_LOW ? SEG_BLANK_AL : ~SEG_BLANK_AL;

   logic [6:0] seg_al;
   logic [6:0] h_d;
   // Power-up value matches the reset value.
   logic [6:0] h_q = BLANK_OUT;

   seg7_lut #(
      .HEX_MODE(HEX_MODE)
   ) u_lut (
      .nib_i(b),
      .seg_o(seg_al)
   );

   always_comb begin
      h_d = SEG_BLANK_AL;
      if (en) begin
         h_d = seg_al;
      end
      if (!ACTIVE_LOW) begin
         h_d = ~h_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q <= BLANK_OUT;
      end else begin
         h_q <= h_d;
      end
   end

   assign h = h_q;

endmodule

// File: tb/tb_bcd_7seg.sv
// Self-checking bench: three configurations of bcd_7seg share stimulus
// and are compared against a table-driven reference model.
module tb_bcd_7seg;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic [3:0] b   = 4'h8;
   logic [6:0] h_def;
   logic [6:0] h_bcd;
   logic [6:0] h_ah;
   logic [6:0] hs [3];

   int n_chk  = 0;
   int n_fail = 0;

   // Per-instance config: 0 = defaults, 1 = BCD mode, 2 = active-high.
   localparam bit HEXM [3] = '{1'b1, 1'b0, 1'b1};
   localparam bit ALOW [3] = '{1'b1, 1'b1, 1'b0};

   // Active-low digit shapes, digits 0..F.
   localparam logic [6:0] TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   bcd_7seg u_def (
      .clk(clk), .rst(rst), .en(en), .b(b), .h(h_def)
   );

   bcd_7seg #(.HEX_MODE(1'b0)) u_bcd (
      .clk(clk), .rst(rst), .en(en), .b(b), .h(h_bcd)
   );

   bcd_7seg #(.ACTIVE_LOW(1'b0)) u_ah (
      .clk(clk), .rst(rst), .en(en), .b(b), .h(h_ah)
   );

   assign hs[0] = h_def;
   assign hs[1] = h_bcd;
   assign hs[2] = h_ah;

   always #5 clk = ~clk;

   function automatic logic [6:0] model(
      int k, logic r, logic e, logic [3:0] v
   );
      logic [6:0] lo;
      int d;
      d  = int'(v);
      lo = 7'h7F;
      if (!r && e && (HEXM[k] || d < 10)) begin
         lo = TBL[d];
      end
      return ALOW[k] ? lo : ~lo;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_powerup();
      #1;
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (hs[k] !== model(k, 1'b1, 1'b0, 4'h0)) begin
            n_fail++;
            $display("FAIL powerup inst%0d got %h exp %h",
               k, hs[k], model(k, 1'b1, 1'b0, 4'h0));
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      b   = 4'h8;
      for (int c = 0; c < 2; c++) begin
         tick();
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (hs[k] !== model(k, 1'b1, en, b)) begin
               n_fail++;
               $display("FAIL reset inst%0d got %h exp %h",
                  k, hs[k], model(k, 1'b1, en, b));
            end
         end
      end
      rst = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (hs[k] !== model(k, 1'b0, en, b)) begin
            n_fail++;
            $display("FAIL reset_release inst%0d got %h exp %h",
               k, hs[k], model(k, 1'b0, en, b));
         end
      end
   endtask

   task automatic test_sweep();
      rst = 1'b0;
      en  = 1'b1;
      for (int v = 0; v < 16; v++) begin
         b = 4'(v);
         tick();
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (hs[k] !== model(k, 1'b0, 1'b1, b)) begin
               n_fail++;
               $display("FAIL sweep b=%h inst%0d got %h exp %h",
                  b, k, hs[k], model(k, 1'b0, 1'b1, b));
            end
         end
      end
   endtask

   task automatic test_latency();
      rst = 1'b0;
      en  = 1'b1;
      b   = 4'h1;
      tick();
      b = 4'h7;
      #3;
      n_chk++;
      if (h_def !== 7'h79) begin
         n_fail++;
         $display("FAIL latency_hold got %h exp 79", h_def);
      end
      tick();
      n_chk++;
      if (h_def !== 7'h78) begin
         n_fail++;
         $display("FAIL latency_update got %h exp 78", h_def);
      end
   endtask

   task automatic test_enable();
      logic [6:0] exp_h [3];
      exp_h = '{7'h12, 7'h7F, 7'h12};
      rst = 1'b0;
      b   = 4'h5;
      for (int s = 0; s < 3; s++) begin
         en = (s != 1);
         tick();
         n_chk++;
         if (h_def !== exp_h[s]) begin
            n_fail++;
            $display("FAIL enable step%0d got %h exp %h",
               s, h_def, exp_h[s]);
         end
         for (int k = 1; k < 3; k++) begin
            n_chk++;
            if (hs[k] !== model(k, 1'b0, en, b)) begin
               n_fail++;
               $display("FAIL enable step%0d inst%0d got %h exp %h",
                  s, k, hs[k], model(k, 1'b0, en, b));
            end
         end
      end
   endtask

   task automatic test_midreset();
      en = 1'b1;
      for (int v = 0; v < 6; v++) begin
         b   = 4'(v + 2);
         rst = (v == 3);
         tick();
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (hs[k] !== model(k, rst, en, b)) begin
               n_fail++;
               $display("FAIL midreset step%0d inst%0d got %h exp %h",
                  v, k, hs[k], model(k, rst, en, b));
            end
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_hold();
      rst = 1'b0;
      en  = 1'b1;
      b   = 4'hC;
      for (int c = 0; c < 10; c++) begin
         tick();
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (hs[k] !== model(k, 1'b0, 1'b1, 4'hC)) begin
               n_fail++;
               $display("FAIL hold cyc%0d inst%0d got %h exp %h",
                  c, k, hs[k], model(k, 1'b0, 1'b1, 4'hC));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         b   = 4'($urandom_range(0, 15));
         en  = ($urandom_range(0, 5) != 0);
         rst = ($urandom_range(0, 15) == 0);
         tick();
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (hs[k] !== model(k, rst, en, b)) begin
               n_fail++;
               $display(
                  "FAIL random c%0d inst%0d r%b e%b b=%h got %h exp %h",
                  c, k, rst, en, b, hs[k], model(k, rst, en, b));
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_powerup();
      test_reset();
      test_sweep();
      test_latency();
      test_enable();
      test_midreset();
      test_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
         n_chk, n_fail);
      $finish;
   end

endmodule
